// File: rtl/gpu_vertex_sequencer_if.sv
// gpu_vertex_sequencer_if: control, vertex-processor and rasterizer signals of the vertex sequencer.
// GPU_SEQ_PERF_EN adds the perf_busy_cycles/perf_wait_cycles counter outputs.
interface gpu_vertex_sequencer_if #(
  parameter int AW    = 14,
  parameter int OUT_W = 11
);
  logic              start;
  logic [31:0]       vertex_count;
  logic              abort;
  logic              src_rd_en;
  logic [AW-1:0]     src_rd_addr;
  logic              proc_in_valid;
  logic              proc_out_valid;
  logic [OUT_W-1:0]  proc_out_data;
  logic [AW-1:0]     rast_rd_addr;
  logic [OUT_W-1:0]  rast_rd_data;
  logic              rast_start;
  logic [31:0]       rast_vertex_count;
  logic              rast_done;
  logic              busy;
  logic              done;
  logic              count_err;
`ifdef GPU_SEQ_PERF_EN
  logic [31:0]       perf_busy_cycles;
  logic [31:0]       perf_wait_cycles;
  modport slave (
    input  start, vertex_count, abort, proc_out_valid, proc_out_data, rast_rd_addr, rast_done,
    output src_rd_en, src_rd_addr, proc_in_valid, rast_rd_data, rast_start, rast_vertex_count,
           busy, done, count_err, perf_busy_cycles, perf_wait_cycles
  );
  modport master (
    output start, vertex_count, abort, proc_out_valid, proc_out_data, rast_rd_addr, rast_done,
    input  src_rd_en, src_rd_addr, proc_in_valid, rast_rd_data, rast_start, rast_vertex_count,
           busy, done, count_err, perf_busy_cycles, perf_wait_cycles
  );
`else
  modport slave (
    input  start, vertex_count, abort, proc_out_valid, proc_out_data, rast_rd_addr, rast_done,
    output src_rd_en, src_rd_addr, proc_in_valid, rast_rd_data, rast_start, rast_vertex_count,
           busy, done, count_err
  );
  modport master (
    output start, vertex_count, abort, proc_out_valid, proc_out_data, rast_rd_addr, rast_done,
    input  src_rd_en, src_rd_addr, proc_in_valid, rast_rd_data, rast_start, rast_vertex_count,
           busy, done, count_err
  );
`endif
endinterface

// File: rtl/gpu_vertex_sequencer.sv
// gpu_vertex_sequencer: vertex fetch sequencing into a ping-pong buffer handed to the rasterizer.
// Optional GPU_SEQ_PERF_EN adds saturating busy/wait cycle counters.
module gpu_vertex_sequencer #(
  parameter int DATA_W     = 18,
  parameter int OUT_W      = 11,
  parameter int DEPTH      = 16384,
  parameter int PRIM_VERTS = 4,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  gpu_vertex_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] PV_MASK = ~(32'(PRIM_VERTS) - 32'd1);
  localparam logic [31:0] DEPTH_R = 32'(DEPTH) & PV_MASK;
  if (DATA_W < 1 || DEPTH < 2 || PRIM_VERTS < 1 || (PRIM_VERTS & (PRIM_VERTS - 1)) != 0 ||
      RD_LAT < 1 || RD_LAT > 4) begin : g_param_err
    $error("gpu_vertex_sequencer: unsupported parameter set");
  end
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WAIT_RAST, HANDOFF} state_e;
  state_e state_q, state_d;
  logic [AW:0] eff_q, eff_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic front_q, front_d, rast_busy_q, rast_busy_d;
  logic rast_start_q, rast_start_d, done_q, done_d, err_q, err_d;
  logic [31:0] rast_cnt_q, rast_cnt_d, masked;
  logic [OUT_W-1:0] rd_data_q;
  logic [OUT_W-1:0] mem [2][DEPTH];
  logic abort_now, wr_act, wr_en;
  always_comb begin
    masked = bus.vertex_count & PV_MASK;
    abort_now = state_q != IDLE && bus.abort;
    wr_act = (state_q == FETCH || state_q == DRAIN) && bus.proc_out_valid && !abort_now;
    wr_en = wr_act && wr_cnt_q != eff_q;
    state_d = state_q;
    eff_d = eff_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_en ? wr_cnt_q + 1'b1 : wr_cnt_q;
    pipe_d = abort_now ? '0 : (pipe_q << 1) | RD_LAT'(state_q == FETCH);
    front_d = front_q ^ rast_start_q;
    rast_busy_d = rast_busy_q && !bus.rast_done;
    rast_start_d = 1'b0;
    done_d = 1'b0;
    rast_cnt_d = rast_cnt_q;
    err_d = err_q || (wr_act && wr_cnt_q == eff_q);
    if (abort_now) begin
      state_d = IDLE;
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          eff_d = masked > 32'(DEPTH) ? DEPTH_R[AW:0] : masked[AW:0];
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          err_d = masked > 32'(DEPTH);
          done_d = masked == '0;
          state_d = masked == '0 ? IDLE : FETCH;
        end
        FETCH: begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          state_d = rd_cnt_q == eff_q - 1'b1 ? DRAIN : FETCH;
        end
        // a rast_done in this very cycle already counts as a free rasterizer
        DRAIN: if (wr_cnt_q == eff_q) state_d = rast_busy_d ? WAIT_RAST : HANDOFF;
        WAIT_RAST: if (bus.rast_done) state_d = HANDOFF;
        HANDOFF: begin
          state_d = IDLE;
          rast_start_d = 1'b1;
          done_d = 1'b1;
          rast_busy_d = 1'b1;
          rast_cnt_d = 32'(eff_q);
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      eff_q <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      pipe_q <= '0;
      front_q <= 1'b0;
      rast_busy_q <= 1'b0;
      rast_start_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      rast_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      eff_q <= eff_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      pipe_q <= pipe_d;
      front_q <= front_d;
      rast_busy_q <= rast_busy_d;
      rast_start_q <= rast_start_d;
      done_q <= done_d;
      err_q <= err_d;
      rast_cnt_q <= rast_cnt_d;
    end
  end
  // front_q flips one cycle after rast_start, so reads issued in the rast_start cycle still see the old bank
  always_ff @(posedge clk) begin
    if (wr_en && reset) mem[~front_q][wr_cnt_q[AW-1:0]] <= bus.proc_out_data;
    rd_data_q <= mem[front_q][bus.rast_rd_addr];
  end
  assign bus.src_rd_en = state_q == FETCH;
  assign bus.src_rd_addr = rd_cnt_q[AW-1:0];
  assign bus.proc_in_valid = pipe_q[RD_LAT-1];
  assign bus.rast_rd_data = rd_data_q;
  assign bus.rast_start = rast_start_q;
  assign bus.rast_vertex_count = rast_cnt_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.count_err = err_q;
`ifdef GPU_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d, perf_wait_q, perf_wait_d;
  always_comb begin
    perf_busy_d = state_q != IDLE && ~&perf_busy_q ? perf_busy_q + 1'b1 : perf_busy_q;
    perf_wait_d = state_q == WAIT_RAST && ~&perf_wait_q ? perf_wait_q + 1'b1 : perf_wait_q;
  end
  always_ff @(posedge clk) begin
    perf_busy_q <= !reset ? '0 : perf_busy_d;
    perf_wait_q <= !reset ? '0 : perf_wait_d;
  end
  assign bus.perf_busy_cycles = perf_busy_q;
  assign bus.perf_wait_cycles = perf_wait_q;
`endif
endmodule

// File: tb/tb_gpu_vertex_sequencer.sv
// tb_gpu_vertex_sequencer: directed checks of fetch, ping-pong handoff, clamp, drop, abort and reset.
module tb_gpu_vertex_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  gpu_vertex_sequencer_if #(.AW(4), .OUT_W(11)) bus ();
  gpu_vertex_sequencer #(.DATA_W(18), .OUT_W(11), .DEPTH(16), .PRIM_VERTS(4), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int n_chk = 0;
  int n_fail = 0;
  logic [2:0] tag = '0;
  logic inj = 1'b0;
  logic [3:0] a_d = '0;
  logic [4:0] pv = '0;
  logic [10:0] pd [5];
  // vertex processor model: latency 5, output = {tag, source address}
  assign bus.proc_out_valid = pv[4] | inj;
  assign bus.proc_out_data = inj ? 11'h7ff : pd[4];
  always @(posedge clk) begin
    a_d <= bus.src_rd_addr;
    pv <= {pv[3:0], bus.proc_in_valid};
    pd[0] <= {4'd0, tag, a_d};
    for (int i = 1; i < 5; i++) pd[i] <= pd[i-1];
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
    end
  endtask
  task automatic fetch(input int cnt, input logic [2:0] tg, input int e);
    bus.vertex_count = 32'(cnt);
    tag = tg;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < e; i++) begin
      chk("fetch_en", 32'(bus.src_rd_en), 1);
      chk("fetch_addr", 32'(bus.src_rd_addr), 32'(i));
      tick();
    end
    chk("fetch_end", 32'(bus.src_rd_en), 0);
  endtask
  task automatic wait_rast(input int exp_wait, input int exp_cnt);
    int n = 0;
    while (!bus.rast_start && n < 40) begin
      tick();
      n++;
    end
    chk("rast_latency", 32'(n), 32'(exp_wait));
    chk("rast_start", 32'(bus.rast_start), 1);
    chk("rast_done_pulse", 32'(bus.done), 1);
    chk("rast_busy_low", 32'(bus.busy), 0);
    chk("rast_vcount", bus.rast_vertex_count, 32'(exp_cnt));
  endtask
  task automatic rd(input logic [3:0] a, input logic [10:0] exp);
    bus.rast_rd_addr = a;
    tick();
    chk("rast_rd_data", 32'(bus.rast_rd_data), 32'(exp));
  endtask
  task automatic release_rast();
    bus.rast_done = 1'b1;
    tick();
    bus.rast_done = 1'b0;
  endtask
  task automatic chk_reset_outs();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_src_en", 32'(bus.src_rd_en), 0);
    chk("rst_piv", 32'(bus.proc_in_valid), 0);
    chk("rst_rast_start", 32'(bus.rast_start), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.count_err), 0);
    chk("rst_addr", 32'(bus.src_rd_addr), 0);
    chk("rst_vcount", bus.rast_vertex_count, 0);
  endtask
  initial begin
    int n;
    bus.start = 1'b0;
    bus.vertex_count = '0;
    bus.abort = 1'b0;
    bus.rast_rd_addr = '0;
    bus.rast_done = 1'b0;
    tick();
    tick();
    chk_reset_outs();
    reset = 1'b1;
    fetch(10, 3'd1, 8);
    chk("basic_err", 32'(bus.count_err), 0);
    wait_rast(8, 8);
    tick();
    rd(4'd0, 11'h10);
    rd(4'd5, 11'h15);
    rd(4'd7, 11'h17);
    bus.vertex_count = 32'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("zero_done", 32'(bus.done), 1);
    chk("zero_busy", 32'(bus.busy), 0);
    chk("zero_src_en", 32'(bus.src_rd_en), 0);
    chk("zero_rast_start", 32'(bus.rast_start), 0);
    tick();
    chk("zero_done_end", 32'(bus.done), 0);
    fetch(4, 3'd2, 4);
    n = 0;
    repeat (15) begin
      tick();
      if (bus.rast_start) n++;
    end
    chk("pp_hold_no_start", 32'(n), 0);
    chk("pp_hold_busy", 32'(bus.busy), 1);
    rd(4'd2, 11'h12);
    release_rast();
    chk("pp_handoff_busy", 32'(bus.busy), 1);
    wait_rast(1, 4);
    tick();
    rd(4'd1, 11'h21);
    rd(4'd3, 11'h23);
    release_rast();
    fetch(40, 3'd3, 16);
    chk("clamp_err", 32'(bus.count_err), 1);
    repeat (6) tick();
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("clamp_err_sticky", 32'(bus.count_err), 1);
    wait_rast(1, 16);
    tick();
    rd(4'd9, 11'h39);
    rd(4'd15, 11'h3f);
    release_rast();
    fetch(5, 3'd4, 4);
    chk("drop_err_cleared", 32'(bus.count_err), 0);
    repeat (6) tick();
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("drop_err_set", 32'(bus.count_err), 1);
    wait_rast(1, 4);
    tick();
    rd(4'd3, 11'h43);
    rd(4'd0, 11'h40);
    release_rast();
    bus.vertex_count = 32'd8;
    tag = 3'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    chk("abort_addr", 32'(bus.src_rd_addr), 3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_src_en", 32'(bus.src_rd_en), 0);
    chk("abort_piv", 32'(bus.proc_in_valid), 0);
    chk("abort_done", 32'(bus.done), 0);
    n = 0;
    repeat (12) begin
      tick();
      if (bus.done || bus.rast_start) n++;
    end
    chk("abort_no_pulse", 32'(n), 0);
    fetch(4, 3'd6, 4);
    chk("post_abort_err", 32'(bus.count_err), 0);
    wait_rast(8, 4);
    tick();
    rd(4'd0, 11'h60);
    rd(4'd3, 11'h63);
    fetch(40, 3'd7, 16);
    release_rast();
    chk("drain_busy", 32'(bus.busy), 1);
    chk("drain_err", 32'(bus.count_err), 1);
    reset = 1'b0;
    tick();
    chk_reset_outs();
    bus.vertex_count = 32'd8;
    bus.start = 1'b1;
    tick();
    chk("rst_start_ignored", 32'(bus.busy), 0);
    chk("rst_start_no_fetch", 32'(bus.src_rd_en), 0);
    reset = 1'b1;
    bus.start = 1'b0;
    tick();
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_done", 32'(bus.done), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
